// File: rtl/comparator_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : comparator_load_sequencer
// Purpose  : Loads two 8-bit operands one nibble at a time from a 4-bit switch
//            bank, using a single debounced pushbutton. After the fourth load
//            it registers one unsigned less/greater/equal result.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            pb     - raw load pushbutton (async, bouncy, active high)
//            y      - nibble switches, sampled only on an accepted press
//            step   - index of the next nibble: 0=A lo,1=A hi,2=B lo,3=B hi
//            a_val  - operand A register
//            b_val  - operand B register
//            valid  - result outputs hold the compare of the current A,B
//            lout   - A < B
//            gout   - A > B
//            eout   - A == B
// Revision : 1.0 - initial release
// ============================================================================
module comparator_load_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb,
    input  logic [3:0] y,
    output logic [1:0] step,
    output logic [7:0] a_val,
    output logic [7:0] b_val,
    output logic       valid,
    output logic       lout,
    output logic       gout,
    output logic       eout
);

    localparam int unsigned c_cnt_w = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    // The accepted level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES, i.e. on the DEBOUNCE_CYCLES-th consecutive mismatch.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        LD_A_LO = 3'd0,
        LD_A_HI = 3'd1,
        LD_B_LO = 3'd2,
        LD_B_HI = 3'd3,
        DONE    = 3'd4
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_accepted;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_press;
    state_t             r_state;
    state_t             w_state_next;

    // ------------------------------------------------------------------------
    // Input conditioning: 2-FF synchroniser, then a stability counter. The
    // press pulse is registered on the same edge that the accepted level
    // rises, so it is high for exactly one cycle per accepted 0->1 change.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_accepted <= 1'b0;
            r_cnt      <= '0;
            r_press    <= 1'b0;
        end else begin
            r_sync1 <= pb;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_accepted) begin
                if (r_cnt == c_cnt_last) begin
                    r_accepted <= r_sync2;
                    r_cnt      <= '0;
                    r_press    <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LD_A_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        step         = 2'd0;
        case (r_state)
            LD_A_LO: begin
                step = 2'd0;
                if (r_press) w_state_next = LD_A_HI;
            end
            LD_A_HI: begin
                step = 2'd1;
                if (r_press) w_state_next = LD_B_LO;
            end
            LD_B_LO: begin
                step = 2'd2;
                if (r_press) w_state_next = LD_B_HI;
            end
            LD_B_HI: begin
                step = 2'd3;
                if (r_press) w_state_next = DONE;
            end
            DONE: begin
                step = 2'd3;
                if (r_press) w_state_next = LD_A_LO;
            end
            default: begin
                step         = 2'd0;
                w_state_next = LD_A_LO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand capture and result register. While in DONE the compare is
    // re-registered every cycle; since the operands cannot change in DONE the
    // result is constant, and valid rises one clock after entering DONE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_val <= 8'h00;
            b_val <= 8'h00;
            valid <= 1'b0;
            lout  <= 1'b0;
            gout  <= 1'b0;
            eout  <= 1'b0;
        end else if (r_press) begin
            case (r_state)
                LD_A_LO: a_val[3:0] <= y;
                LD_A_HI: a_val[7:4] <= y;
                LD_B_LO: b_val[3:0] <= y;
                LD_B_HI: b_val[7:4] <= y;
                DONE: begin
                    // Press in DONE starts a fresh sequence; y is ignored.
                    a_val <= 8'h00;
                    b_val <= 8'h00;
                    valid <= 1'b0;
                    lout  <= 1'b0;
                    gout  <= 1'b0;
                    eout  <= 1'b0;
                end
                default: ;
            endcase
        end else if (r_state == DONE) begin
            valid <= 1'b1;
            lout  <= (a_val <  b_val);
            gout  <= (a_val >  b_val);
            eout  <= (a_val == b_val);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comparator_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparator_load_sequencer
// Purpose  : Self-checking bench for comparator_load_sequencer. Stimulus pushes
//            expected compare results into a queue; a monitor pops and checks
//            them whenever valid rises, and checks the result invariant on
//            every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_load_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pb;
    logic [3:0] y;
    logic [1:0] step;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic       valid;
    logic       lout;
    logic       gout;
    logic       eout;

    int passed = 0;
    int total  = 0;

    // {a, b, lout, gout, eout}
    logic [18:0] exp_q[$];
    logic        prev_valid = 1'b0;

    comparator_load_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pb    (pb),
        .y     (y),
        .step  (step),
        .a_val (a_val),
        .b_val (b_val),
        .valid (valid),
        .lout  (lout),
        .gout  (gout),
        .eout  (eout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: result invariant every clock, scoreboard pop on valid rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) check("onehot_result", 32'($onehot({lout, gout, eout})), 32'd1);
            else       check("idle_result_zero", {29'd0, lout, gout, eout}, 32'd0);
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    check("result", {13'd0, a_val, b_val, lout, gout, eout}, {13'd0, e});
                end
            end
        end
        prev_valid <= valid;
    end

    // One accepted press: y held stable through the capture, then released
    // while y wanders randomly (must have no effect).
    task automatic press(input logic [3:0] v);
        y  = v;
        pb = 1'b1;
        repeat (12) @(posedge clk);
        #1 pb = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 y = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic sequence4(input logic [3:0] n0, input logic [3:0] n1,
                             input logic [3:0] n2, input logic [3:0] n3,
                             input logic [18:0] expv);
        press(n0);
        press(n1);
        press(n2);
        exp_q.push_back(expv);
        press(n3);
        @(negedge clk);
        check("step_done", 32'(step), 32'd3);
        check("valid_done", 32'(valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        pb    = 1'b0;
        y     = 4'h0;
        #12;
        // Reset state
        check("rst_step", 32'(step), 32'd0);
        check("rst_a", 32'(a_val), 32'd0);
        check("rst_b", 32'(b_val), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_lge", {29'd0, lout, gout, eout}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // T1: equal
        sequence4(4'hD, 4'h0, 4'hD, 4'h0, {8'h0D, 8'h0D, 3'b001});
        press(4'h7);
        @(negedge clk);
        check("t1_clear_step", 32'(step), 32'd0);

        // T2: greater
        sequence4(4'h0, 4'hF, 4'hF, 4'hE, {8'hF0, 8'hEF, 3'b010});
        press(4'h3);

        // T3: less, then press in DONE clears everything
        sequence4(4'h0, 4'h0, 4'hF, 4'hF, {8'h00, 8'hFF, 3'b100});
        press(4'hA);
        @(negedge clk);
        check("t3_valid", 32'(valid), 32'd0);
        check("t3_lge", {29'd0, lout, gout, eout}, 32'd0);
        check("t3_step", 32'(step), 32'd0);
        check("t3_a", 32'(a_val), 32'd0);
        check("t3_b", 32'(b_val), 32'd0);

        // T4: short glitches, then a held press with exact latency
        @(posedge clk);
        #1 y = 4'hA;
        pb = 1'b1;
        repeat (3) @(posedge clk);
        #1 pb = 1'b0;
        @(posedge clk);
        #1 pb = 1'b1;
        repeat (3) @(posedge clk);
        #1 pb = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_glitch_step", 32'(step), 32'd0);
        @(posedge clk);
        #1 pb = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t4_step_before", 32'(step), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t4_step_after", 32'(step), 32'd1);
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("t4_held_once", 32'(step), 32'd1);
        check("t4_a_lo", 32'(a_val), 32'h0A);
        @(posedge clk);
        #1 pb = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // T5: finish loading A=0x5A, then reset mid-sequence
        press(4'h5);
        @(negedge clk);
        check("t5_a", 32'(a_val), 32'h5A);
        check("t5_step_pre", 32'(step), 32'd2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_step", 32'(step), 32'd0);
        check("t5_rst_a", 32'(a_val), 32'd0);
        check("t5_rst_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sequence4(4'h1, 4'h0, 4'h2, 4'h0, {8'h01, 8'h02, 3'b100});

        // T6: random y between presses already exercised; one more mixed case
        press(4'h0);
        sequence4(4'h9, 4'h3, 4'h8, 4'h3, {8'h39, 8'h38, 3'b010});

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
